// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIter = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_add_sub.sv
// Parametrised adder/subtractor; sub_i selects a - b via two's complement of b.
module seq_divider_add_sub #(
  parameter int unsigned Width = 9
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             sub_i,
  output logic [Width-1:0] sum_o
);

  logic [Width-1:0] b_eff;

  always_comb begin
    b_eff = b_i ^ {Width{sub_i}};
    sum_o = a_i + b_eff + Width'(sub_i);
  end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider with start/done handshake; one quotient bit per cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero,
  output logic         rem_eq0
);

  localparam int unsigned CW = $clog2(N) + 1;

  state_e        state_q, state_d;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          div_zero_q, div_zero_d;
  logic          rem_eq0_q, rem_eq0_d;

  logic [N:0] shifted;
  logic [N:0] trial;

  // A stays below 2*M, so its top bit is never shifted back in.
  logic unused_a_msb;
  assign unused_a_msb = a_q[N];

  assign shifted = {a_q[N-1:0], q_q[N-1]};

  seq_divider_add_sub #(
    .Width(N + 1)
  ) u_trial_sub (
    .a_i  (shifted),
    .b_i  ({1'b0, m_q}),
    .sub_i(1'b1),
    .sum_o(trial)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    q_d        = q_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    rem_eq0_d  = rem_eq0_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor != '0) begin
            a_d        = '0;
            q_d        = dividend;
            m_d        = divisor;
            cnt_d      = CW'(N);
            div_zero_d = 1'b0;
            state_d    = StIter;
          end else begin
            quot_d     = '1;
            rem_d      = dividend;
            div_zero_d = 1'b1;
            rem_eq0_d  = (dividend == '0);
            state_d    = StDone;
          end
        end
      end
      StIter: begin
        // Negative trial result restores the shifted partial remainder.
        a_d   = trial[N] ? shifted : trial;
        q_d   = {q_q[N-2:0], ~trial[N]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quot_d    = q_d;
          rem_d     = a_d[N-1:0];
          rem_eq0_d = (a_d == '0);
          state_d   = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      a_q        <= '0;
      q_q        <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      rem_eq0_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      q_q        <= q_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
      rem_eq0_q  <= rem_eq0_d;
    end
  end

  always_comb begin
    busy      = (state_q == StIter);
    done      = (state_q == StDone);
    quotient  = quot_q;
    remainder = rem_q;
    div_zero  = div_zero_q;
    rem_eq0   = rem_eq0_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at N=8 and N=16.
module tb_seq_divider;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  dvd8 = '0, dvs8 = '0;
  logic        busy8, done8, dz8, re8;
  logic [7:0]  q8, r8;

  logic        start16 = 1'b0;
  logic [15:0] dvd16 = '0, dvs16 = '0;
  logic        busy16, done16, dz16, re16;
  logic [15:0] q16, r16;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  seq_divider #(.N(8)) dut8 (
    .clock    (clock),
    .reset    (reset),
    .start    (start8),
    .dividend (dvd8),
    .divisor  (dvs8),
    .busy     (busy8),
    .done     (done8),
    .quotient (q8),
    .remainder(r8),
    .div_zero (dz8),
    .rem_eq0  (re8)
  );

  seq_divider #(.N(16)) dut16 (
    .clock    (clock),
    .reset    (reset),
    .start    (start16),
    .dividend (dvd16),
    .divisor  (dvs16),
    .busy     (busy16),
    .done     (done16),
    .quotient (q16),
    .remainder(r16),
    .div_zero (dz16),
    .rem_eq0  (re16)
  );

  // Launches one operation and waits (bounded) for done; cyc=0 means timeout.
  task automatic run_op(input bit wide, input logic [15:0] dvd, input logic [15:0] dvs,
                        input bit hold, output int cyc, output bit busy_seen,
                        output bit done_at_launch, output logic [15:0] q_mid);
    @(negedge clock);
    done_at_launch = wide ? done16 : done8;
    if (wide) begin
      start16 = 1'b1; dvd16 = dvd; dvs16 = dvs;
    end else begin
      start8 = 1'b1; dvd8 = dvd[7:0]; dvs8 = dvs[7:0];
    end
    cyc = 0;
    busy_seen = 1'b0;
    q_mid = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (wide ? busy16 : busy8) busy_seen = 1'b1;
      if (i == 4) q_mid = wide ? q16 : {8'h00, q8};
      if (wide ? done16 : done8) begin
        cyc = i;
        break;
      end
      if (hold) begin
        dvd8 = 8'(i * 37);
        dvs8 = 8'(i * 11 + 1);
      end else begin
        start8 = 1'b0;
        start16 = 1'b0;
      end
    end
    start8 = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({busy8, done8, q8, r8, dz8, re8} !== 20'h0) begin
      tests_failed++;
      $display("FAIL reset8: got %h want 0", {busy8, done8, q8, r8, dz8, re8});
    end
    tests_run++;
    if ({busy16, done16, q16, r16, dz16, re16} !== 36'h0) begin
      tests_failed++;
      $display("FAIL reset16: got %h want 0", {busy16, done16, q16, r16, dz16, re16});
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; bit bs; bit dl; logic [15:0] qm;
    run_op(1'b0, 16'd100, 16'd7, 1'b0, cyc, bs, dl, qm);
    tests_run++;
    if (cyc !== 9 || bs !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_latency: got cyc=%0d busy=%0b want cyc=9 busy=1", cyc, bs);
    end
    tests_run++;
    if ({q8, r8, dz8, re8} !== {8'd14, 8'd2, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%0b eq0=%0b want q=14 r=2 dz=0 eq0=0",
               q8, r8, dz8, re8);
    end
    @(negedge clock);
    tests_run++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_pulse: got done=%0b busy=%0b want 0 0", done8, busy8);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit bs; bit dl; logic [15:0] qm;
    run_op(1'b0, 16'd255, 16'd1, 1'b0, cyc, bs, dl, qm);
    tests_run++;
    if (cyc !== 9 || {q8, r8, re8} !== {8'd255, 8'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_first: got cyc=%0d q=%0d r=%0d eq0=%0b want 9 255 0 1",
               cyc, q8, r8, re8);
    end
    run_op(1'b0, 16'd0, 16'd3, 1'b0, cyc, bs, dl, qm);
    tests_run++;
    if (dl !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_pulse_width: got done=%0b in cycle after done want 0", dl);
    end
    tests_run++;
    if (qm !== 16'd255) begin
      tests_failed++;
      $display("FAIL b2b_hold: got q=%0d mid-op want 255", qm);
    end
    tests_run++;
    if (cyc !== 9 || {q8, r8, re8} !== {8'd0, 8'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_second: got cyc=%0d q=%0d r=%0d eq0=%0b want 9 0 0 1",
               cyc, q8, r8, re8);
    end
    @(negedge clock);
    tests_run++;
    if (done8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_pulse2: got done=%0b want 0", done8);
    end
  endtask

  task automatic test_div_zero();
    int cyc; bit bs; bit dl; logic [15:0] qm;
    run_op(1'b0, 16'd5, 16'd0, 1'b0, cyc, bs, dl, qm);
    tests_run++;
    if (cyc !== 1 || bs !== 1'b0) begin
      tests_failed++;
      $display("FAIL dz_latency: got cyc=%0d busy=%0b want cyc=1 busy=0", cyc, bs);
    end
    tests_run++;
    if ({q8, r8, dz8, re8} !== {8'hFF, 8'd5, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL dz_result: got q=%h r=%0d dz=%0b eq0=%0b want ff 5 1 0", q8, r8, dz8, re8);
    end
    run_op(1'b0, 16'd9, 16'd3, 1'b0, cyc, bs, dl, qm);
    tests_run++;
    if (qm !== 16'h00FF) begin
      tests_failed++;
      $display("FAIL dz_hold: got q=%h mid-op want ff", qm);
    end
    tests_run++;
    if (cyc !== 9 || {q8, r8, dz8, re8} !== {8'd3, 8'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL dz_clear: got cyc=%0d q=%0d r=%0d dz=%0b eq0=%0b want 9 3 0 0 1",
               cyc, q8, r8, dz8, re8);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc; bit bs; bit dl; logic [15:0] qm;
    int extra_done;
    int extra_busy;
    run_op(1'b0, 16'd3, 16'd200, 1'b1, cyc, bs, dl, qm);
    tests_run++;
    if (cyc !== 9 || {q8, r8} !== {8'd0, 8'd3}) begin
      tests_failed++;
      $display("FAIL hold_result: got cyc=%0d q=%0d r=%0d want 9 0 3", cyc, q8, r8);
    end
    extra_done = 0;
    extra_busy = 0;
    repeat (12) begin
      @(negedge clock);
      if (done8) extra_done++;
      if (busy8) extra_busy++;
    end
    tests_run++;
    if (extra_done !== 0 || extra_busy !== 0) begin
      tests_failed++;
      $display("FAIL hold_single: got %0d done %0d busy cycles after want 0 0",
               extra_done, extra_busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc; bit bs; bit dl; logic [15:0] qm;
    int seen_done;
    @(negedge clock);
    start8 = 1'b1; dvd8 = 8'd200; dvs8 = 8'd9;
    @(negedge clock);
    start8 = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({busy8, done8, q8, r8, dz8, re8} !== 20'h0) begin
      tests_failed++;
      $display("FAIL rst_mid: got %h want 0", {busy8, done8, q8, r8, dz8, re8});
    end
    @(negedge clock);
    reset = 1'b0;
    seen_done = 0;
    repeat (12) begin
      @(negedge clock);
      if (done8) seen_done++;
    end
    tests_run++;
    if (seen_done !== 0) begin
      tests_failed++;
      $display("FAIL rst_no_done: got %0d done pulses want 0", seen_done);
    end
    run_op(1'b0, 16'd200, 16'd9, 1'b0, cyc, bs, dl, qm);
    tests_run++;
    if (cyc !== 9 || {q8, r8} !== {8'd22, 8'd2}) begin
      tests_failed++;
      $display("FAIL rst_rerun: got cyc=%0d q=%0d r=%0d want 9 22 2", cyc, q8, r8);
    end
  endtask

  task automatic test_wide();
    int cyc; bit bs; bit dl; logic [15:0] qm;
    logic [15:0] vec_dvd [4];
    logic [15:0] vec_dvs [4];
    logic [15:0] vec_q   [4];
    logic [15:0] vec_r   [4];
    logic [15:0] a, b;
    vec_dvd = '{16'd65535, 16'd1000, 16'd40000, 16'd12345};
    vec_dvs = '{16'd255,   16'd7,    16'd300,   16'd12346};
    vec_q   = '{16'd257,   16'd142,  16'd133,   16'd0};
    vec_r   = '{16'd0,     16'd6,    16'd100,   16'd12345};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, vec_dvd[i], vec_dvs[i], 1'b0, cyc, bs, dl, qm);
      tests_run++;
      if (cyc !== 17 || {q16, r16, dz16, re16} !== {vec_q[i], vec_r[i], 1'b0, vec_r[i] == 16'd0})
      begin
        tests_failed++;
        $display("FAIL wide_vec%0d: got cyc=%0d q=%0d r=%0d dz=%0b eq0=%0b want 17 %0d %0d",
                 i, cyc, q16, r16, dz16, re16, vec_q[i], vec_r[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom);
      b = 16'($urandom_range(1, 65535));
      run_op(1'b1, a, b, 1'b0, cyc, bs, dl, qm);
      tests_run++;
      if (cyc !== 17 || q16 !== a / b || r16 !== a % b) begin
        tests_failed++;
        $display("FAIL wide_rand %0d/%0d: got cyc=%0d q=%0d r=%0d want 17 %0d %0d",
                 a, b, cyc, q16, r16, a / b, a % b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid_op();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
